adder_tree_accumulator: RTL and testbench
=========================================

// Module: adder_tree_accumulator
//
// PURPOSE
// Downstream consumer of the adder tree output. Takes one reduced sum per beat over a valid/ready
// handshake and accumulates NUM_ACC consecutive beats into one wider partial sum. The result is
// emitted on a valid/ready output handshake. Signed or unsigned accumulation follows the same
// sign_unsign_ni convention as the tree; inputs are 2's complement when signed.
//
// PARAMETERS
// DATAW    12                         width of each incoming tree sum
// NUM_ACC  8                          beats accumulated per result, >= 1
// ACCW     DATAW+$clog2(NUM_ACC)      derived output width; cannot overflow
//
// PORTS
// clk_i           in   1                   clock
// rst_ni          in   1                   asynchronous reset, active-low
// data_i          in   DATAW               incoming tree sum
// sign_unsign_ni  in   1                   1 = signed, 0 = unsigned; sampled on the first beat of a frame
// valid_i         in   1                   data_i valid
// ready_o         out  1                   beat accepted when valid_i && ready_o
// clear_i         in   1                   synchronous abort of the current frame
// data_o          out  ACCW                accumulated result
// valid_o         out  1                   data_o valid
// ready_i         in   1                   result consumed when valid_o && ready_i
// count_o         out  $clog2(NUM_ACC+1)   beats accepted in the current frame
//
// BEHAVIOUR
// - Reset (rst_ni low, asynchronous): state=IDLE, acc=0, count_o=0, valid_o=0, data_o=0, mode=0.
//   ready_o=0 while rst_ni is low.
// - Extension: each beat is sign-extended (latched mode=1) or zero-extended (mode=0) to ACCW.
// - FSM IDLE:
//   - ready_o=1.
//   - On handshake: acc<=ext(data_i), mode<=sign_unsign_ni, count<=1.
//   - Next state: OUTPUT if NUM_ACC==1, else ACCUM.
// - FSM ACCUM:
//   - ready_o=1.
//   - On handshake: acc<=acc+ext(data_i), count++.
//   - When the accepted beat is beat NUM_ACC: go to OUTPUT.
//   - sign_unsign_ni is ignored after the first beat.
// - FSM OUTPUT:
//   - valid_o=1, data_o=acc, ready_o=ready_i.
//   - data_o and valid_o are held stable while !ready_i.
//   - On output handshake without an input beat: go to IDLE, count<=0.
//   - On output handshake with a simultaneous input beat: that beat is the first beat of the next
//     frame (load as in IDLE, next state per NUM_ACC). No bubble.
// - Latency: valid_o rises the cycle after the handshake of beat NUM_ACC.
//   Throughput is one beat per cycle with ready_i held high.
// - clear_i has priority over every handshake in every state:
//   - next state IDLE, acc=0, count=0, valid_o=0.
//   - A pending result in OUTPUT is discarded; this is the only permitted valid_o drop without a
//     handshake.
//   - Any beat presented in the clear_i cycle is not accepted; ready_o=0 while clear_i=1.
// - Arithmetic is exact in ACCW bits:
//   - unsigned range [0, NUM_ACC*(2^DATAW-1)];
//   - signed range [NUM_ACC*-2^(DATAW-1), NUM_ACC*(2^(DATAW-1)-1)].
// - count_o equals the number of beats in acc: NUM_ACC in OUTPUT, 0 in IDLE.
//
// TESTING (DATAW=4, NUM_ACC=4, ACCW=6)
// 1. Signed: beats F,F,1,2 with sign_unsign_ni=1 -> data_o=6'h01, valid_o 1 cycle after beat 4.
// 2. Unsigned: same beats with sign_unsign_ni=0 -> data_o=6'h21 (33).
// 3. Extremes: 4x F unsigned -> 6'h3C. 4x 8 signed -> 6'h20 (-32).
//    Mode toggled after beat 1 -> result unchanged.
// 4. Backpressure: ready_i=0 for 5 cycles in OUTPUT -> data_o/valid_o stable, ready_o=0.
//    Then ready_i=1 with valid_i=1, data_i=3 -> result consumed, count_o=1 next cycle, no bubble.
// 5. clear_i after 2 beats, then beats 1,1,1,1 -> data_o=6'h04. clear_i while valid_o -> valid_o=0
//    next cycle, result lost.
// 6. rst_ni low mid-frame (after 3 beats) -> all outputs 0 immediately. After release, 4 new beats
//    give only their own sum.

Source files
------------

// File: rtl/adder_tree_accumulator.sv
// Accumulates NUM_ACC consecutive adder-tree sums into one wider result.
// Input and output use valid/ready handshakes, and back-to-back frames run without a bubble.
module adder_tree_accumulator #(
  parameter  int DATAW   = 12,
  parameter  int NUM_ACC = 8,
  parameter  int ACCW    = DATAW + $clog2(NUM_ACC),
  localparam int CNTW    = $clog2(NUM_ACC + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DATAW-1:0] data_i,
  input  logic             sign_unsign_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic [ACCW-1:0]  data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNTW-1:0]  count_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_e;

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUM_ACC - 1);

  state_e          state, next_state, first_state;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] ext_data;
  logic [CNTW-1:0] count;
  logic            mode;
  logic            ext_signed;
  logic            in_fire;
  logic            out_fire;

  assign in_fire     = valid_i && ready_o;
  assign out_fire    = valid_o && ready_i && !clear_i;
  assign first_state = (NUM_ACC == 1) ? OUTPUT : ACCUM;

  // The first beat of a frame, including one overlapping an output handshake, uses the live mode bit.
  always_comb begin
    ext_signed = (state == ACCUM) ? mode : sign_unsign_ni;
    ext_data   = ext_signed ? ACCW'($signed(data_i)) : ACCW'(data_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_fire) next_state = first_state;
      ACCUM:   if (in_fire && count == LAST_CNT) next_state = OUTPUT;
      OUTPUT:  if (out_fire) next_state = in_fire ? first_state : IDLE;
      default: next_state = IDLE;
    endcase
    if (clear_i) next_state = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc   <= '0;
      count <= '0;
      mode  <= 1'b0;
    end else if (clear_i) begin
      acc   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            acc   <= ext_data;
            mode  <= sign_unsign_ni;
            count <= CNTW'(1);
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc   <= acc + ext_data;
            count <= count + CNTW'(1);
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (in_fire) begin
              acc   <= ext_data;
              mode  <= sign_unsign_ni;
              count <= CNTW'(1);
            end else begin
              acc   <= '0;
              count <= '0;
            end
          end
        end
        default: begin
          acc   <= '0;
          count <= '0;
        end
      endcase
    end
  end

  // ready_o is gated by rst_ni so that no beat appears accepted while reset is held.
  always_comb begin
    valid_o = (state == OUTPUT);
    data_o  = valid_o ? acc : '0;
    count_o = count;
    ready_o = rst_ni && !clear_i && ((state == OUTPUT) ? ready_i : 1'b1);
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed test of adder_tree_accumulator at DATAW=4, NUM_ACC=4, ACCW=6.
// Expected values are hand-computed constants.
module tb_adder_tree_accumulator;

  localparam int DATAW   = 4;
  localparam int NUM_ACC = 4;
  localparam int ACCW    = 6;
  localparam int CNTW    = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [DATAW-1:0] data_i = '0;
  logic             sign_unsign_ni = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic             clear_i = 1'b0;
  logic [ACCW-1:0]  data_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [CNTW-1:0]  count_o;

  int total = 0;
  int bad   = 0;

  adder_tree_accumulator #(
    .DATAW  (DATAW),
    .NUM_ACC(NUM_ACC)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .sign_unsign_ni(sign_unsign_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .clear_i       (clear_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [DATAW-1:0] d, input logic s);
    valid_i        = 1'b1;
    data_i         = d;
    sign_unsign_ni = s;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic frame(input logic [DATAW-1:0] d0, input logic [DATAW-1:0] d1,
                       input logic [DATAW-1:0] d2, input logic [DATAW-1:0] d3, input logic s);
    beat(d0, s);
    beat(d1, s);
    beat(d2, s);
    beat(d3, s);
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_valid_after_consume"}, 32'(valid_o), 32'd0);
    check({tag, "_count_after_consume"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    #2;
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_data", 32'(data_o), 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    #10 rst_ni = 1'b1;
    tick();
    check("idle_ready", 32'(ready_o), 32'd1);

    // 1: signed -1-1+1+2 = 1, valid one cycle after beat 4
    beat(4'hF, 1'b1);
    beat(4'hF, 1'b1);
    beat(4'h1, 1'b1);
    check("t1_count3", 32'(count_o), 32'd3);
    check("t1_no_valid_before_last", 32'(valid_o), 32'd0);
    beat(4'h2, 1'b1);
    check("t1_valid", 32'(valid_o), 32'd1);
    check("t1_data", 32'(data_o), 32'h01);
    check("t1_count4", 32'(count_o), 32'd4);
    consume("t1");

    // 2: unsigned 15+15+1+2 = 33
    frame(4'hF, 4'hF, 4'h1, 4'h2, 1'b0);
    check("t2_data", 32'(data_o), 32'h21);
    consume("t2");

    // 3: extremes and mode latched on beat 1
    frame(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    check("t3_unsigned_max", 32'(data_o), 32'h3C);
    consume("t3a");
    frame(4'h8, 4'h8, 4'h8, 4'h8, 1'b1);
    check("t3_signed_min", 32'(data_o), 32'h20);
    consume("t3b");
    beat(4'hF, 1'b1);
    beat(4'hF, 1'b0);
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    check("t3_mode_latched", 32'(data_o), 32'h01);
    consume("t3c");

    // 4: backpressure, then overlapping consume and next first beat
    frame(4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    valid_i = 1'b1;
    data_i  = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(valid_o), 32'd1);
      check("t4_hold_data", 32'(data_o), 32'h04);
      check("t4_hold_ready", 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("t4_ready_follows", 32'(ready_o), 32'd1);
    tick();
    check("t4_nobubble_count", 32'(count_o), 32'd1);
    check("t4_nobubble_valid", 32'(valid_o), 32'd0);
    tick();
    tick();
    tick();
    valid_i = 1'b0;
    check("t4_second_valid", 32'(valid_o), 32'd1);
    check("t4_second_data", 32'(data_o), 32'h0C);
    ready_i = 1'b0;
    consume("t4");

    // 5: clear mid-frame and clear of a pending result
    beat(4'h5, 1'b0);
    beat(4'h5, 1'b0);
    clear_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 4'h7;
    #1;
    check("t5_clear_ready", 32'(ready_o), 32'd0);
    tick();
    clear_i = 1'b0;
    valid_i = 1'b0;
    check("t5_clear_count", 32'(count_o), 32'd0);
    frame(4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    check("t5_after_clear", 32'(data_o), 32'h04);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t5_drop_valid", 32'(valid_o), 32'd0);
    check("t5_drop_data", 32'(data_o), 32'd0);
    check("t5_drop_count", 32'(count_o), 32'd0);

    // 6: asynchronous reset mid-frame
    beat(4'h7, 1'b0);
    beat(4'h7, 1'b0);
    beat(4'h7, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_count", 32'(count_o), 32'd0);
    check("t6_rst_ready", 32'(ready_o), 32'd0);
    check("t6_rst_valid", 32'(valid_o), 32'd0);
    #2 rst_ni = 1'b1;
    tick();
    frame(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
    check("t6_fresh_valid", 32'(valid_o), 32'd1);
    check("t6_fresh_data", 32'(data_o), 32'h08);
    consume("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
